// File: rtl/intr_ctrl_pkg.sv
// Shared constants and the FSM state encoding for the interrupt controller.
package lib_intr;

  // Number of interrupt sources. The top index is the internal timer.
  localparam int N_SRC       = 4;
  // Width of the internal cause index.
  localparam int CAUSE_W     = $clog2(N_SRC);
  // Width of the cause value as the CPU reads it.
  localparam int CAUSE_OUT_W = 32;
  // Width of the timer period and counter.
  localparam int TMR_W       = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-facing signal bundle of the interrupt controller.
//
// Handshake: the controller raises irq (registered) and holds cause stable
// while the request is outstanding. The CPU answers with a one-cycle take
// pulse when it vectors to the handler, which drops irq on the next cycle.
// When the handler finishes, the CPU sends a one-cycle ack pulse, which
// clears the pending bit of the serviced cause. take is honoured only while
// a request is outstanding and ack only while a cause is being serviced;
// at any other time both are ignored.
interface intr_ctrl_if #(
  parameter int N_SRC = lib_intr::N_SRC
);
  import lib_intr::*;

  logic [N_SRC-2:0]       src_pulse;
  logic                   intr_en;
  logic                   take;
  logic                   ack;
  logic                   mask_we;
  logic [N_SRC-1:0]       mask_wdata;
  logic                   tmr_we;
  logic [TMR_W-1:0]       tmr_wdata;
  logic                   irq;
  logic [CAUSE_OUT_W-1:0] cause;
  logic [N_SRC-1:0]       pending;
  logic [1:0]             state;

  // Controller side.
  modport slave (
    input  src_pulse, intr_en, take, ack, mask_we, mask_wdata, tmr_we, tmr_wdata,
    output irq, cause, pending, state
  );

  // CPU / stimulus side.
  modport master (
    output src_pulse, intr_en, take, ack, mask_we, mask_wdata, tmr_we, tmr_wdata,
    input  irq, cause, pending, state
  );

endinterface

// File: rtl/intr_ctrl_timer.sv
// Periodic timer: a down-counter that emits a one-cycle tick each time it
// reaches zero, then reloads period - 1. A period of 0 stops the timer.
module intr_timer #(
  parameter int W = lib_intr::TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic         tick
);

  logic [W-1:0] r_period;
  logic [W-1:0] r_count;
  logic         w_tick;

  // Terminal count is decoded from registered state, so a write landing on
  // the same cycle cannot suppress the tick that is already due.
  assign w_tick = (r_period != '0) && (r_count == '0);
  assign tick   = w_tick;

  // Period register and down-counter; a write always wins over the reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_count  <= '0;
    end else if (we) begin
      r_period <= wdata;
      r_count  <= (wdata == '0) ? '0 : wdata - W'(1);
    end else if (w_tick) begin
      r_count  <= r_period - W'(1);
    end else if (r_count != '0) begin
      r_count  <= r_count - W'(1);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches source events into a pending register,
// selects the lowest-index enabled source, and runs a request/service
// handshake with the CPU.
module intr_ctrl #(
  parameter int N_SRC = lib_intr::N_SRC
) (
  input  logic      clk,
  input  logic      reset,
  intr_ctrl_if.slave bus
);
  import lib_intr::*;

  localparam int CW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_REQ     = 2'(REQ);
  localparam logic [1:0] S_SERVICE = 2'(SERVICE);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_irq;
  logic [CW-1:0]    r_cause;
  logic [CW-1:0]    w_win_idx;
  logic             w_any;
  logic             w_start;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] w_event;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_elig;
  logic             w_tick;

  intr_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (bus.tmr_we),
    .wdata (bus.tmr_wdata),
    .tick  (w_tick)
  );

  // The timer occupies the highest source index.
  assign w_event = {w_tick, bus.src_pulse};
  assign w_elig  = r_pending & r_mask;

  // Fixed priority: the lowest set index of the eligible vector wins.
  always_comb begin
    w_win_idx = '0;
    w_any     = |w_elig;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_idx = CW'(i);
      end
    end
  end

  // Clear of the serviced cause, only on an ack that arrives in SERVICE.
  always_comb begin
    w_clr = '0;
    if ((r_state == S_SERVICE) && bus.ack) begin
      w_clr[r_cause] = 1'b1;
    end
  end

  assign w_start = w_any && bus.intr_en;

  // Next-state logic; take and ack are only looked at in their own state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.take) begin
          w_state_nxt = S_SERVICE;
        end else if (!bus.intr_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (bus.ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, registered irq and cause; cause is captured only on entry to REQ
  // so it stays frozen through the request and the service.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= (w_state_nxt == S_REQ);
      if ((r_state == S_IDLE) && w_start) begin
        r_cause <= w_win_idx;
      end
    end
  end

  // Pending latch: a new event beats a clear landing on the same bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_event;
    end
  end

  // Mask register; a write becomes visible to the eligibility check next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (bus.mask_we) begin
      r_mask <= bus.mask_wdata;
    end
  end

  assign bus.irq     = r_irq;
  assign bus.cause   = {{(CAUSE_OUT_W - CW){1'b0}}, r_cause};
  assign bus.pending = r_pending;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl. Expected interrupt causes are queued when
// stimulus is issued and popped by a monitor on each rising edge of irq.
module tb_intr_ctrl;

  localparam int W = 32;
  localparam logic [W-1:0] ST_IDLE    = 32'd0;
  localparam logic [W-1:0] ST_REQ     = 32'd1;
  localparam logic [W-1:0] ST_SERVICE = 32'd2;

  logic clk;
  logic reset;

  intr_ctrl_if #(.N_SRC(4)) bus ();

  intr_ctrl #(.N_SRC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_irq = 1'b0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new interrupt request must match the next queued cause.
  always @(negedge clk) begin
    if (bus.irq && !prev_irq) begin
      if (exp_q.size() == 0) begin
        check("unexpected_irq_cause", bus.cause, 32'hFFFF_FFFF);
      end else begin
        check("irq_cause", bus.cause, exp_q.pop_front());
      end
    end
    prev_irq = bus.irq;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    step();
    bus.mask_we    = 1'b0;
  endtask

  task automatic write_tmr(input logic [31:0] p);
    bus.tmr_we    = 1'b1;
    bus.tmr_wdata = p;
    step();
    bus.tmr_we    = 1'b0;
  endtask

  task automatic pulse_src(input logic [2:0] s);
    bus.src_pulse = s;
    step();
    bus.src_pulse = 3'b000;
  endtask

  task automatic do_take();
    bus.take = 1'b1;
    step();
    bus.take = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tick_at[$];
    int n_ticks;

    reset          = 1'b1;
    bus.src_pulse  = '0;
    bus.intr_en    = 1'b0;
    bus.take       = 1'b0;
    bus.ack        = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.tmr_we     = 1'b0;
    bus.tmr_wdata  = '0;
    step(3);
    check("rst_irq",     32'(bus.irq),     32'd0);
    check("rst_cause",   bus.cause,        32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_state",   32'(bus.state),   ST_IDLE);
    reset = 1'b0;
    step();

    // Single source through the full handshake.
    bus.intr_en = 1'b1;
    write_mask(4'b0011);
    exp_q.push_back(32'd1);
    pulse_src(3'b010);
    check("t1_pending", 32'(bus.pending), 32'h2);
    check("t1_irq_lat", 32'(bus.irq),     32'd0);
    step();
    check("t1_irq",     32'(bus.irq),     32'd1);
    check("t1_cause",   bus.cause,        32'd1);
    do_take();
    check("t1_irq_tk",  32'(bus.irq),     32'd0);
    check("t1_st_srv",  32'(bus.state),   ST_SERVICE);
    step(2);
    do_ack();
    check("t1_pend_ack", 32'(bus.pending), 32'h0);
    check("t1_st_idle",  32'(bus.state),   ST_IDLE);
    step();
    check("t1_irq_end",  32'(bus.irq),     32'd0);

    // Two sources together: lowest index first, then the other.
    write_mask(4'hF);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd2);
    pulse_src(3'b101);
    check("t2_pending", 32'(bus.pending), 32'h5);
    step();
    check("t2_cause0",  bus.cause,        32'd0);
    do_take();
    do_ack();
    check("t2_pend_a",  32'(bus.pending), 32'h4);
    step();
    check("t2_irq2",    32'(bus.irq),     32'd1);
    check("t2_cause2",  bus.cause,        32'd2);
    do_take();
    do_ack();
    check("t2_pend_b",  32'(bus.pending), 32'h0);

    // Enable withdrawn while requesting, then restored.
    exp_q.push_back(32'd0);
    pulse_src(3'b001);
    step();
    check("t3_irq",     32'(bus.irq),     32'd1);
    bus.intr_en = 1'b0;
    step();
    check("t3_irq_off", 32'(bus.irq),     32'd0);
    check("t3_st_idle", 32'(bus.state),   ST_IDLE);
    check("t3_pend",    32'(bus.pending), 32'h1);
    step(2);
    check("t3_irq_off2", 32'(bus.irq),    32'd0);
    exp_q.push_back(32'd0);
    bus.intr_en = 1'b1;
    step();
    check("t3_irq_back", 32'(bus.irq),    32'd1);
    check("t3_cause",    bus.cause,       32'd0);
    do_take();
    do_ack();
    check("t3_pend_clr", 32'(bus.pending), 32'h0);

    // Stray ack in REQ is ignored; re-event on the ack cycle keeps pending.
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    pulse_src(3'b010);
    step();
    do_ack();
    check("t4_st_req",  32'(bus.state),   ST_REQ);
    check("t4_pend",    32'(bus.pending), 32'h2);
    do_take();
    bus.ack       = 1'b1;
    bus.src_pulse = 3'b010;
    step();
    bus.ack       = 1'b0;
    bus.src_pulse = 3'b000;
    check("t4_pend_set_wins", 32'(bus.pending), 32'h2);
    check("t4_st_idle", 32'(bus.state),   ST_IDLE);
    step();
    check("t4_irq_re",  32'(bus.irq),     32'd1);
    do_take();
    do_ack();
    check("t4_pend_clr", 32'(bus.pending), 32'h0);

    // Cause stays frozen when a higher-priority source arrives during REQ;
    // masking the current cause in SERVICE does not abort it.
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd0);
    pulse_src(3'b100);
    step();
    pulse_src(3'b001);
    check("t5_cause_frz", bus.cause,      32'd2);
    check("t5_irq_held",  32'(bus.irq),   32'd1);
    do_take();
    write_mask(4'b0001);
    check("t5_st_srv",    32'(bus.state), ST_SERVICE);
    do_ack();
    check("t5_pend",      32'(bus.pending), 32'h1);
    step();
    do_take();
    do_ack();
    check("t5_pend_clr",  32'(bus.pending), 32'h0);

    // Timer: period 5, then off, then period 1. Enable kept low.
    bus.intr_en = 1'b0;
    write_mask(4'h8);
    write_tmr(32'd5);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (dut.u_timer.tick) tick_at.push_back(k);
    end
    while (tick_at.size() < 3) tick_at.push_back(-1);
    check("tmr_tick1", 32'(tick_at[0]), 32'd4);
    check("tmr_tick2", 32'(tick_at[1]), 32'd9);
    check("tmr_tick3", 32'(tick_at[2]), 32'd14);
    write_tmr(32'd0);
    n_ticks = 0;
    for (int k = 0; k < 15; k++) begin
      if (dut.u_timer.tick) n_ticks++;
      step();
    end
    check("tmr_off_ticks", 32'(n_ticks), 32'd0);
    write_tmr(32'd1);
    n_ticks = 0;
    for (int k = 0; k < 4; k++) begin
      if (dut.u_timer.tick) n_ticks++;
      step();
    end
    write_tmr(32'd0);
    check("tmr_p1_ticks", 32'(n_ticks), 32'd4);
    check("tmr_pend",     32'(bus.pending), 32'h8);
    exp_q.push_back(32'd3);
    bus.intr_en = 1'b1;
    step();
    check("tmr_irq",      32'(bus.irq),   32'd1);
    check("tmr_cause",    bus.cause,      32'd3);
    do_take();
    do_ack();
    step(10);
    check("tmr_quiet",    32'(bus.pending), 32'h0);

    // Reset in SERVICE with pending = 1010; a later ack does nothing.
    write_mask(4'hF);
    exp_q.push_back(32'd1);
    bus.tmr_we    = 1'b1;
    bus.tmr_wdata = 32'd1;
    bus.src_pulse = 3'b010;
    step();
    bus.src_pulse = 3'b000;
    bus.tmr_wdata = 32'd0;
    step();
    bus.tmr_we    = 1'b0;
    check("t7_pend",     32'(bus.pending), 32'hA);
    do_take();
    check("t7_st_srv",   32'(bus.state),   ST_SERVICE);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7_irq",      32'(bus.irq),     32'd0);
    check("t7_cause",    bus.cause,        32'd0);
    check("t7_pend_rst", 32'(bus.pending), 32'h0);
    check("t7_st_rst",   32'(bus.state),   ST_IDLE);
    do_ack();
    check("t7_ack_pend", 32'(bus.pending), 32'h0);
    check("t7_ack_st",   32'(bus.state),   ST_IDLE);
    step(5);
    check("t7_no_irq",   32'(bus.irq),     32'd0);

    // ---------------- report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
